// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_target slice.
//   state_t   : protocol FSM states of the target
//   RW_WRITE  : R/W bit value for a master write
//   RW_READ   : R/W bit value for a master read
//   BYTE_DONE : bit-counter value once all 8 bits of a byte have been clocked
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_BYTE,
        WRITE_ACK,
        READ_BYTE,
        READ_ACK
    } state_t;

    localparam logic       RW_WRITE  = 1'b0;
    localparam logic       RW_READ   = 1'b1;
    localparam logic [3:0] BYTE_DONE = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one open-drain bus line.
// A 2-flop synchronizer is followed by a glitch filter: the filtered level
// only changes after FILTER_DEPTH consecutive synchronized samples disagree
// with it, so pin-to-level latency is 2 + FILTER_DEPTH cycles.
// Ports:
//   clk_in : system clock
//   rst_n  : synchronous active-low reset (level resets to 1 = released bus)
//   pin    : raw bus line
//   level  : filtered level
//   rise   : one-cycle pulse, high in the first cycle level is 1
//   fall   : one-cycle pulse, high in the first cycle level is 0
module i2c_line_filter #(
    parameter int FILTER_DEPTH = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] agree_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            level     <= 1'b1;
            agree_cnt <= 4'd0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            // synchronizer stages
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            // filter stage: any sample matching the current level restarts the run
            if (sync_p1 == level) begin
                agree_cnt <= 4'd0;
            end else if (agree_cnt == 4'(FILTER_DEPTH - 1)) begin
                level     <= sync_p1;
                agree_cnt <= 4'd0;
                rise      <= sync_p1;
                fall      <= ~sync_p1;
            end else begin
                agree_cnt <= agree_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target. Oversamples SCL/SDA on clk_in, detects
// START / repeated START / STOP, matches a 7-bit address and exchanges bytes
// with user logic through strobes. SDA (and SCL when stretching) are only
// ever pulled low, never driven high.
// Optional feature macro: I2C_TARGET_CLOCK_STRETCH_EN -- when defined, SCL is
// held low at a byte-load point until tx_valid is seen.
// Ports:
//   clk_in, rst_n      : clock, synchronous active-low reset
//   scl, sda           : open-drain bus lines
//   ack_en             : ACK (1) / NACK (0) master-written bytes
//   data_tx, tx_valid  : byte returned on master read, its valid flag
//   tx_req             : next read byte is being captured
//   data_rx, rx_valid  : last written byte and its update strobe
//   addressed, mode    : target selected, R/W bit of the transfer
//   start_det, stop_det: bus condition strobes
//   nack               : master NACKed a read byte
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS        = 7'h50,
    parameter int         FILTER_DEPTH   = 3,
    parameter int         INPUT_CLK_RATE = 500000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    inout  wire        scl,
    inout  wire        sda,
    input  logic       ack_en,
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       addressed,
    output logic       mode,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_cond, stop_cond;
    logic need_load;
    logic unused_cfg;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_rx_q, data_rx_d;
    logic       sda_low_q, sda_low_d;
    logic       mode_q, mode_d;
    logic       addressed_q, addressed_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       nack_q, nack_d;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    logic       scl_low_q, scl_low_d;
    logic       stretch_q, stretch_d;
`else
    logic       unused_tx_valid;
`endif

    // INPUT_CLK_RATE only documents the required clk_in/SCL ratio
    assign unused_cfg = (INPUT_CLK_RATE > 0);

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin    (scl),
        .level  (scl_f),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pin    (sda),
        .level  (sda_f),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    assign start_cond = sda_fall && scl_f;
    assign stop_cond  = sda_rise && scl_f;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            data_rx_q   <= 8'h00;
            sda_low_q   <= 1'b0;
            mode_q      <= RW_WRITE;
            addressed_q <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            nack_q      <= 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            scl_low_q   <= 1'b0;
            stretch_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_rx_q   <= data_rx_d;
            sda_low_q   <= sda_low_d;
            mode_q      <= mode_d;
            addressed_q <= addressed_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            nack_q      <= nack_d;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            scl_low_q   <= scl_low_d;
            stretch_q   <= stretch_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_rx_d   = data_rx_q;
        sda_low_d   = sda_low_q;
        mode_d      = mode_q;
        addressed_d = addressed_q;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        nack_d      = 1'b0;
        need_load   = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        scl_low_d   = scl_low_q;
        stretch_d   = stretch_q;
`endif

        case (state_q)
            ADDR: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_f};
                    cnt_d   = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == BYTE_DONE) begin
                    if (shift_q[7:1] == ADDRESS) begin
                        sda_low_d   = 1'b1;
                        mode_d      = shift_q[0] ? RW_READ : RW_WRITE;
                        addressed_d = 1'b1;
                        state_d     = ADDR_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    sda_low_d = 1'b0;
                    cnt_d     = 4'd0;
                    if (mode_q == RW_WRITE) state_d = WRITE_BYTE;
                    else                    need_load = 1'b1;
                end
            end
            WRITE_BYTE: begin
                if (scl_rise) begin
                    shift_d = {shift_q[6:0], sda_f};
                    cnt_d   = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == BYTE_DONE) begin
                    data_rx_d  = shift_q;
                    rx_valid_d = 1'b1;
                    sda_low_d  = ack_en;
                    cnt_d      = 4'd0;
                    state_d    = WRITE_ACK;
                end
            end
            WRITE_ACK: begin
                if (scl_fall) begin
                    sda_low_d = 1'b0;
                    state_d   = WRITE_BYTE;
                end
            end
            READ_BYTE: begin
                if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (cnt_q == BYTE_DONE) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 4'd0;
                        state_d   = READ_ACK;
                    end else begin
                        // shift[7] is already on the bus; present the next bit
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_low_d = ~shift_q[6];
                    end
                end
            end
            READ_ACK: begin
                if (scl_rise && sda_f) begin
                    nack_d      = 1'b1;
                    addressed_d = 1'b0;
                    sda_low_d   = 1'b0;
                    state_d     = IDLE;
                end else if (scl_fall) begin
                    cnt_d     = 4'd0;
                    need_load = 1'b1;
                end
            end
            default: ;
        endcase

        // Byte load for master reads: capture data_tx and put its MSB on SDA
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
        if (stretch_q) begin
            if (tx_valid) begin
                shift_d   = data_tx;
                sda_low_d = ~data_tx[7];
                state_d   = READ_BYTE;
                scl_low_d = 1'b0;
                stretch_d = 1'b0;
            end else begin
                tx_req_d = 1'b1;
            end
        end else if (need_load) begin
            tx_req_d = 1'b1;
            if (tx_valid) begin
                shift_d   = data_tx;
                sda_low_d = ~data_tx[7];
                state_d   = READ_BYTE;
            end else begin
                // SCL is already low here, so holding it cannot glitch the bus
                scl_low_d = 1'b1;
                stretch_d = 1'b1;
            end
        end
`else
        if (need_load) begin
            shift_d   = data_tx;
            sda_low_d = ~data_tx[7];
            tx_req_d  = 1'b1;
            state_d   = READ_BYTE;
        end
`endif

        if (stop_cond) begin
            stop_det_d  = 1'b1;
            addressed_d = 1'b0;
            sda_low_d   = 1'b0;
            state_d     = IDLE;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            scl_low_d   = 1'b0;
            stretch_d   = 1'b0;
`endif
        end

        // START wins if both ever appear together
        if (start_cond) begin
            start_det_d = 1'b1;
            stop_det_d  = 1'b0;
            addressed_d = 1'b0;
            sda_low_d   = 1'b0;
            cnt_d       = 4'd0;
            state_d     = ADDR;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
            scl_low_d   = 1'b0;
            stretch_d   = 1'b0;
`endif
        end
    end

    assign sda = sda_low_q ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    assign scl = scl_low_q ? 1'b0 : 1'bz;
`else
    assign scl = 1'bz;
    assign unused_tx_valid = tx_valid;
`endif

    assign data_rx   = data_rx_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign addressed = addressed_q;
    assign mode      = mode_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign nack      = nack_q;

endmodule
